osd_ram_write_arbiter: RTL and testbench
========================================

// Module: osd_ram_write_arbiter
// PURPOSE
//  Owns the single OSD character RAM write port. Merges single-cycle I2C OSD writes with a
//  hardware fill engine that clears/fills a RAM region (e.g. blank OSD page on menu change).
//  Sits between the I2C register block and the OSD RAM; I2C writes always win, fill stalls.
// PARAMETERS
//  ADDR_W   10  RAM address width (8 pages x 128 chars)
//  DATA_W    8  RAM data width (character code)
//  LEN_W    11  fill length width; max length 2**ADDR_W
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  i2c_wren     in   1       I2C OSD write strobe, 1-cycle pulse, never stalled
//  i2c_addr     in   ADDR_W  I2C write address
//  i2c_data     in   DATA_W  I2C write data
//  fill_start   in   1       start fill; sampled only in IDLE
//  fill_abort   in   1       abort running fill
//  fill_base    in   ADDR_W  first fill address (sampled at accepted start)
//  fill_len     in   LEN_W   number of words to write (sampled at accepted start)
//  fill_char    in   DATA_W  fill value (sampled at accepted start)
//  ram_wren     out  1       RAM write enable
//  ram_wraddress out ADDR_W  RAM write address
//  ram_dataIn   out  DATA_W  RAM write data
//  fill_busy    out  1       high while state != IDLE
//  fill_done    out  1       1-cycle pulse when fill completes or is aborted
//  fill_stalls  out  16      count of fill cycles lost to I2C, saturating, cleared at start
// BEHAVIOUR
//  - All outputs registered; reset: ram_wren=0, ram_wraddress=0, ram_dataIn=0, fill_busy=0,
//    fill_done=0, fill_stalls=0, state=IDLE. Reset mid-fill drops fill; no further writes.
//  - Latency: port request in cycle N -> ram_* valid in cycle N+1, one write per cycle max.
//  - Priority: i2c_wren=1 -> RAM gets i2c_addr/i2c_data that cycle; fill does not advance,
//    fill_stalls += 1 if state=FILL (saturate at 16'hFFFF).
//  - FSM: IDLE, FILL, DONE.
//    IDLE: fill_start=1 -> latch base/len/char, cnt<=len, ptr<=base, fill_stalls<=0;
//          len==0 -> DONE, else FILL. fill_start in FILL/DONE ignored.
//    FILL: if !i2c_wren: write ptr/char, ptr<=ptr+1 mod 2**ADDR_W, cnt<=cnt-1;
//          cnt==1 on that write -> DONE. fill_abort=1 -> DONE, no write that cycle
//          (abort has priority over the fill write, not over I2C).
//    DONE: fill_done=1 for one cycle, -> IDLE. fill_busy high in FILL and DONE.
//  - Address wrap: base+len > 2**ADDR_W wraps to 0; len=2**ADDR_W writes whole RAM once.
//  - fill_len > 2**ADDR_W: clamped to 2**ADDR_W.
//  - Simultaneous fill_start and fill_abort in IDLE: start accepted, abort ignored.
//  - ram_wren=0 in any cycle with no I2C write and no fill write; address/data hold.
// TESTING
//  - I2C only: i2c_wren at addr 0x085 data 0x41 -> next cycle ram_wren=1, 0x085/0x41, single pulse.
//  - Fill base 0x100 len 128 char 0x20, no I2C -> 128 writes 0x100..0x17F on consecutive cycles,
//    fill_done pulse 1 cycle after last write, fill_busy 0 thereafter.
//  - Fill len 16 with I2C writes on 3 fill cycles -> I2C data lands unaltered, fill completes
//    16 writes in 19 cycles, fill_stalls=3.
//  - Wrap: base 0x3FE len 4 -> writes 0x3FE,0x3FF,0x000,0x001; len 0 -> no write, done pulse.
//  - Abort after 5 writes -> exactly 5 writes, fill_done pulse, state IDLE; new start accepted.
//  - Reset asserted mid-fill -> all outputs at reset values next cycle, no further ram_wren.

Source files
------------

// File: rtl/osd_ram_write_arbiter.sv
// Single owner of the OSD character RAM write port: merges I2C writes with a
// region fill engine. I2C always wins; the fill engine stalls and counts lost cycles.
module osd_ram_write_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_wren,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_char,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [15:0]       fill_stalls
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic [15:0]       stalls_d;
  logic              wren_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [LEN_W-1:0]  len_clamped;

  // Lengths beyond the RAM size would only rewrite the same words again.
  assign len_clamped = (fill_len > MAX_LEN) ? MAX_LEN : fill_len;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    char_d   = char_q;
    stalls_d = fill_stalls;
    wren_d   = 1'b0;
    addr_d   = ram_wraddress;
    data_d   = ram_dataIn;

    if (i2c_wren) begin
      wren_d = 1'b1;
      addr_d = i2c_addr;
      data_d = i2c_data;
    end

    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          cnt_d    = len_clamped;
          ptr_d    = fill_base;
          char_d   = fill_char;
          stalls_d = '0;
          state_d  = (len_clamped == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (i2c_wren && fill_stalls != 16'hFFFF) stalls_d = fill_stalls + 16'd1;
        // Abort beats the fill write but never the I2C write above.
        if (fill_abort) begin
          state_d = DONE;
        end else if (!i2c_wren) begin
          wren_d = 1'b1;
          addr_d = ptr_q;
          data_d = char_q;
          ptr_d  = ptr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      char_q        <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_dataIn    <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      fill_stalls   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      char_q        <= char_d;
      ram_wren      <= wren_d;
      ram_wraddress <= addr_d;
      ram_dataIn    <= data_d;
      fill_busy     <= (state_q != IDLE);
      fill_done     <= (state_q == DONE);
      fill_stalls   <= stalls_d;
    end
  end

endmodule

// File: tb/tb_osd_ram_write_arbiter.sv
// Bench for osd_ram_write_arbiter: I2C vector table, directed fill sequences and
// randomized traffic scored cycle by cycle against a queue-based reference model.
module tb_osd_ram_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i2c_wren = 1'b0;
  logic [9:0]  i2c_addr = '0;
  logic [7:0]  i2c_data = '0;
  logic        fill_start = 1'b0;
  logic        fill_abort = 1'b0;
  logic [9:0]  fill_base = '0;
  logic [10:0] fill_len = '0;
  logic [7:0]  fill_char = '0;
  logic        ram_wren;
  logic [9:0]  ram_wraddress;
  logic [7:0]  ram_dataIn;
  logic        fill_busy;
  logic        fill_done;
  logic [15:0] fill_stalls;

  osd_ram_write_arbiter dut (
    .clk(clk), .reset(reset),
    .i2c_wren(i2c_wren), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
    .fill_len(fill_len), .fill_char(fill_char),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_dataIn(ram_dataIn),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_stalls(fill_stalls)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t wlog[$];
  int  done_cyc[$];

  // Reference model: expected output values plus the pending fill as an address list.
  logic        m_wren, m_busy_o, m_done_o;
  logic [9:0]  m_addr;
  logic [7:0]  m_data, m_char;
  logic [15:0] m_stalls;
  bit          m_busy, m_ending;
  logic [9:0]  m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int len;
    if (reset) begin
      m_wren = 0; m_addr = '0; m_data = '0; m_busy_o = 0; m_done_o = 0; m_stalls = '0;
      m_busy = 0; m_ending = 0; m_q.delete();
      return;
    end
    m_wren   = 1'b0;
    m_busy_o = m_busy;
    m_done_o = m_ending;
    if (i2c_wren) begin
      m_wren = 1'b1; m_addr = i2c_addr; m_data = i2c_data;
    end
    if (!m_busy) begin
      if (fill_start) begin
        len = (int'(fill_len) > 1024) ? 1024 : int'(fill_len);
        m_q.delete();
        for (int i = 0; i < len; i++) m_q.push_back(10'((int'(fill_base) + i) % 1024));
        m_char = fill_char; m_stalls = '0; m_busy = 1; m_ending = (len == 0);
      end
    end else if (m_ending) begin
      m_busy = 0; m_ending = 0;
    end else begin
      if (i2c_wren && m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
      if (fill_abort) begin
        m_q.delete(); m_ending = 1;
      end else if (!i2c_wren) begin
        m_wren = 1'b1; m_addr = m_q.pop_front(); m_data = m_char;
        if (m_q.size() == 0) m_ending = 1;
      end
    end
  endtask

  task automatic tick();
    wr_t w;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("ram_wren", ram_wren, m_wren);
    check("ram_wraddress", ram_wraddress, m_addr);
    check("ram_dataIn", ram_dataIn, m_data);
    check("fill_busy", fill_busy, m_busy_o);
    check("fill_done", fill_done, m_done_o);
    check("fill_stalls", fill_stalls, m_stalls);
    if (ram_wren === 1'b1) begin
      w.cyc = cyc; w.addr = ram_wraddress; w.data = ram_dataIn;
      wlog.push_back(w);
    end
    if (fill_done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic start_fill(input logic [9:0] base, input logic [10:0] len, input logic [7:0] ch);
    fill_start = 1'b1; fill_base = base; fill_len = len; fill_char = ch;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0 = done_cyc.size();
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cyc.size() > n0) seen = 1;
    end
    check({name, "_done_within_budget"}, seen, 1);
  endtask

  task automatic clear_logs();
    wlog.delete();
    done_cyc.delete();
  endtask

  typedef struct {
    logic       wren;
    logic [9:0] addr;
    logic [7:0] data;
    logic       exp_wren;
    logic [9:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int bad;
    logic [9:0] wrap_exp[4];
    int r;

    vecs[0] = '{1'b1, 10'h085, 8'h41, 1'b1, 10'h085, 8'h41};
    vecs[1] = '{1'b0, 10'h3C3, 8'h77, 1'b0, 10'h085, 8'h41};
    vecs[2] = '{1'b1, 10'h3FF, 8'hFF, 1'b1, 10'h3FF, 8'hFF};
    vecs[3] = '{1'b1, 10'h000, 8'h00, 1'b1, 10'h000, 8'h00};
    vecs[4] = '{1'b0, 10'h123, 8'h55, 1'b0, 10'h000, 8'h00};
    vecs[5] = '{1'b1, 10'h2AA, 8'h5A, 1'b1, 10'h2AA, 8'h5A};
    vecs[6] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h2AA, 8'h5A};

    // Reset values
    reset = 1'b1;
    tick(); tick();
    check("rst_wren", ram_wren, 0);
    check("rst_addr", ram_wraddress, 0);
    check("rst_busy", fill_busy, 0);
    check("rst_done", fill_done, 0);
    check("rst_stalls", fill_stalls, 0);
    reset = 1'b0;
    tick();

    // I2C-only vector table
    foreach (vecs[i]) begin
      i2c_wren = vecs[i].wren; i2c_addr = vecs[i].addr; i2c_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d_wren", i), ram_wren, vecs[i].exp_wren);
      check($sformatf("vec%0d_addr", i), ram_wraddress, vecs[i].exp_addr);
      check($sformatf("vec%0d_data", i), ram_dataIn, vecs[i].exp_data);
    end
    i2c_wren = 1'b0;
    tick();

    // 128-word fill, no I2C
    clear_logs();
    start_fill(10'h100, 11'd128, 8'h20);
    wait_done(200, "fill128");
    bad = 0;
    foreach (wlog[i])
      if (wlog[i].addr != 10'(10'h100 + i) || wlog[i].data != 8'h20 || wlog[i].cyc != wlog[0].cyc + i) bad++;
    check("fill128_count", wlog.size(), 128);
    check("fill128_seq_errors", bad, 0);
    check("fill128_done_count", done_cyc.size(), 1);
    if (wlog.size() > 0 && done_cyc.size() > 0)
      check("fill128_done_after_last", done_cyc[0], wlog[wlog.size()-1].cyc + 1);
    tick();
    check("fill128_busy_after", fill_busy, 0);

    // 16-word fill with three I2C interruptions
    clear_logs();
    start_fill(10'h200, 11'd16, 8'h2A);
    for (int k = 0; k < 25; k++) begin
      i2c_wren = (k == 2 || k == 5 || k == 9);
      i2c_addr = 10'(10'h010 + k);
      i2c_data = 8'hA5;
      tick();
    end
    i2c_wren = 1'b0;
    begin
      int nf = 0, ni = 0, first = -1, last = -1, ibad = 0;
      foreach (wlog[i]) begin
        if (wlog[i].data == 8'h2A) begin
          nf++;
          if (first < 0) first = wlog[i].cyc;
          last = wlog[i].cyc;
        end else begin
          ni++;
          if (wlog[i].data != 8'hA5 || !(wlog[i].addr inside {10'h012, 10'h015, 10'h019})) ibad++;
        end
      end
      check("stall_fill_writes", nf, 16);
      check("stall_i2c_writes", ni, 3);
      check("stall_i2c_unaltered", ibad, 0);
      check("stall_span_cycles", last - first + 1, 19);
      check("stall_count", fill_stalls, 3);
      check("stall_done_count", done_cyc.size(), 1);
    end

    // Address wrap and zero length
    clear_logs();
    wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
    start_fill(10'h3FE, 11'd4, 8'h11);
    wait_done(20, "wrap");
    check("wrap_count", wlog.size(), 4);
    bad = 0;
    foreach (wlog[i]) if (i < 4 && wlog[i].addr != wrap_exp[i]) bad++;
    check("wrap_addr_errors", bad, 0);
    clear_logs();
    start_fill(10'h055, 11'd0, 8'h33);
    wait_done(10, "len0");
    check("len0_writes", wlog.size(), 0);
    tick();

    // Over-length fill clamps to the whole RAM once
    clear_logs();
    start_fill(10'h005, 11'h7FF, 8'h44);
    wait_done(1100, "clamp");
    check("clamp_count", wlog.size(), 1024);
    if (wlog.size() > 0) begin
      check("clamp_first", wlog[0].addr, 10'h005);
      check("clamp_last", wlog[wlog.size()-1].addr, 10'h004);
    end
    tick();

    // Abort after five writes, then a fresh start with abort held in IDLE
    clear_logs();
    start_fill(10'h080, 11'd50, 8'h66);
    for (int i = 0; i < 30 && wlog.size() < 5; i++) tick();
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    wait_done(10, "abort");
    tick();
    check("abort_writes", wlog.size(), 5);
    check("abort_busy_after", fill_busy, 0);
    clear_logs();
    fill_abort = 1'b1;
    start_fill(10'h090, 11'd3, 8'h77);
    fill_abort = 1'b0;
    wait_done(10, "restart");
    check("restart_writes", wlog.size(), 3);
    tick();

    // Reset mid-fill
    clear_logs();
    start_fill(10'h000, 11'd100, 8'h99);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_wren", ram_wren, 0);
    check("midrst_busy", fill_busy, 0);
    clear_logs();
    repeat (20) tick();
    check("midrst_no_writes", wlog.size(), 0);
    check("midrst_no_done", done_cyc.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      i2c_wren   = ($urandom_range(0, 9) < 3);
      i2c_addr   = 10'($urandom);
      i2c_data   = 8'($urandom);
      fill_start = ($urandom_range(0, 19) == 0);
      fill_abort = ($urandom_range(0, 49) == 0);
      fill_base  = 10'($urandom);
      fill_char  = 8'($urandom);
      r = $urandom_range(0, 9);
      fill_len   = (r == 0) ? 11'($urandom_range(1025, 2047)) :
                   (r == 1) ? 11'd0 : 11'($urandom_range(1, 40));
      reset      = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; i2c_wren = 1'b0; fill_start = 1'b0; fill_abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
